mac_4bit_tap_seq: RTL
=====================

// Module: mac_4bit_tap_seq
// PURPOSE
//  Operand sequencer directly upstream of the 4-bit MAC in the eFPGA math unit.
//  - Accepts a valid/ready stream of (operand, coefficient) pairs and groups them into N-tap dot-product jobs.
//  - Drives the MAC's enable, clear/round, TC, SAT and OUT_SEL controls from registers.
//  - Captures the MAC's 4-bit output after the last tap and presents it on a valid/ready result port.
// PARAMETERS
//  TAP_W   4   width of tap-count config; a job is 1..2**TAP_W taps
// PORTS
//  MAC_ACC_CLK         in   1      clock
//  acc_ff_rstn         in   1      reset; asynchronous, active-low
//  seq_abort           in   1      synchronous job abort
//  cfg_taps            in   TAP_W  taps-1 for next job
//  cfg_out_sel         in   6      output shift select (0..16)
//  cfg_tc              in   1      1 = signed operands
//  cfg_rnd             in   1      1 = seed accumulator with round constant
//  cfg_sat             in   1      1 = saturate output
//  in_valid            in   1      tap available
//  in_ready            out  1      tap accepted when in_valid & in_ready
//  in_oper, in_coef    in   4      tap operand / coefficient
//  MAC_OPER_DATA       out  4      to MAC, registered
//  MAC_COEF_DATA       out  4      to MAC, registered
//  EFPGA_MATHB_CLK_EN  out  1      to MAC, accumulate strobe
//  MAC_ACC_CLEAR       out  1      to MAC
//  MAC_ACC_RND         out  1      to MAC
//  MAC_ACC_SAT         out  1      to MAC
//  MAC_TC              out  1      to MAC
//  MAC_OUT_SEL         out  6      to MAC
//  MAC_OUT             in   4      from MAC, combinational on its accumulator
//  res_valid           out  1      result available
//  res_ready           in   1      result consumed when res_valid & res_ready
//  res_data            out  4      captured MAC_OUT
//  busy                out  1      state != IDLE
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; tap_rem 0.
//  FSM states: IDLE, RUN, FLUSH, CAPTURE, RESULT.
//  in_ready is 1 in IDLE and RUN only.
//  Tap accept at edge k:
//   - MAC_OPER_DATA <= in_oper; MAC_COEF_DATA <= in_coef; EFPGA_MATHB_CLK_EN <= 1.
//   - The MAC accumulates at edge k+1.
//   - EFPGA_MATHB_CLK_EN <= 0 on any edge without an accept.
//  Job start (accept in IDLE):
//   - Latch cfg_* into MAC_OUT_SEL, MAC_TC, MAC_ACC_SAT; all held constant until the job returns to IDLE.
//   - First-tap seeding: MAC_ACC_CLEAR <= ~cfg_rnd; MAC_ACC_RND <= cfg_rnd.
//   - Round constant is 1<<(OUT_SEL-1) for OUT_SEL 1..16; for OUT_SEL 0 it is 0.
//   - Both seed strobes are 0 on later taps.
//   - tap_rem <= cfg_taps. Next state: RUN if cfg_taps != 0, else FLUSH.
//  RUN:
//   - Each accept decrements tap_rem; the accept with tap_rem == 1 goes to FLUSH.
//   - in_valid gaps are allowed: CLK_EN stays 0 and the accumulator holds.
//  FLUSH:  one cycle (last MAC update occurs) -> CAPTURE.
//  CAPTURE: res_data <= MAC_OUT; res_valid <= 1 -> RESULT.
//  RESULT:
//   - Hold res_data/res_valid stable until res_ready, then res_valid <= 0 -> IDLE.
//   - The next job's first tap can be accepted on the cycle after the handshake.
//  Latency: last tap accepted at edge k -> res_valid high after edge k+2.
//  Throughput: one tap per cycle within a job; 3 cycles of overhead per job.
//  seq_abort (any state):
//   - -> IDLE next edge; res_valid, CLK_EN, CLEAR and RND <= 0.
//   - Has priority over a simultaneous accept or res handshake; in_ready is forced 0 that cycle.
//  Reset mid-job: the job is lost, the MAC is reset by the same net, and no stale result appears.
//  Arithmetic: performed entirely in the MAC (20-bit accumulator); no overflow checking in this block.
//  cfg_out_sel > 16: passed through unchanged; the MAC treats it as 0.
// TESTING
//  T1 unsigned, out_sel=0, sat=0, taps=0, tap (3,5):
//     res_data=4'hF with res_valid high exactly 2 edges after the accept.
//  T2 unsigned, sat=1, taps=0, tap (15,15)=225: res_data=4'hF.
//     Signed, sat=1, taps=1, taps (7,7),(7,7): res_data=4'h7.
//  T3 out_sel=2, tap (3,2), taps=0: rnd=1 -> res_data=2; rnd=0 -> res_data=1.
//  T4 4-tap signed job (-2,3),(1,1),(-1,-1),(2,2), in_valid gaps of 3 cycles, res_ready low 5 cycles:
//     res_data=0, held stable; in_ready=0 throughout RESULT.
//  T5 back-to-back jobs 9*1 then 2*1, unsigned, out_sel=0, sat=0:
//     results 9 then 2 (CLEAR on first tap discards the prior accumulator).
//  T6 seq_abort after tap 2 of a 4-tap job, and separately acc_ff_rstn pulse mid-job; then 1-tap job (4,2):
//     res_data=8, no spurious res_valid.

Source files
------------

// File: rtl/mac_4bit_tap_seq.sv
// Operand sequencer in front of the 4-bit MAC: groups valid/ready taps into
// N-tap jobs, drives registered MAC controls and returns the captured result.
module mac_4bit_tap_seq #(
  parameter int TAP_W = 4
) (
  input  logic             MAC_ACC_CLK,
  input  logic             acc_ff_rstn,
  input  logic             seq_abort,
  input  logic [TAP_W-1:0] cfg_taps,
  input  logic [5:0]       cfg_out_sel,
  input  logic             cfg_tc,
  input  logic             cfg_rnd,
  input  logic             cfg_sat,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_oper,
  input  logic [3:0]       in_coef,
  output logic [3:0]       MAC_OPER_DATA,
  output logic [3:0]       MAC_COEF_DATA,
  output logic             EFPGA_MATHB_CLK_EN,
  output logic             MAC_ACC_CLEAR,
  output logic             MAC_ACC_RND,
  output logic             MAC_ACC_SAT,
  output logic             MAC_TC,
  output logic [5:0]       MAC_OUT_SEL,
  input  logic [3:0]       MAC_OUT,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [3:0]       res_data,
  output logic             busy
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_FLUSH   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_RESULT  = 3'd4
  } state_t;

  localparam logic [TAP_W-1:0] TAP_ZERO = {TAP_W{1'b0}};
  localparam logic [TAP_W-1:0] TAP_ONE  = {{(TAP_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [TAP_W-1:0] tap_rem_q, tap_rem_d;
  logic [3:0]       oper_q, oper_d;
  logic [3:0]       coef_q, coef_d;
  logic             clk_en_q, clk_en_d;
  logic             clear_q, clear_d;
  logic             rnd_q, rnd_d;
  logic             sat_q, sat_d;
  logic             tc_q, tc_d;
  logic [5:0]       out_sel_q, out_sel_d;
  logic             res_valid_q, res_valid_d;
  logic [3:0]       res_data_q, res_data_d;
  logic             busy_q, busy_d;
  logic             in_ready_s;
  logic             accept_s;

  // Abort wins over any accept in the same cycle, so ready is gated by it.
  assign in_ready_s = ~seq_abort & ((state_q == ST_IDLE) | (state_q == ST_RUN));
  assign accept_s   = in_valid & in_ready_s;

  // Next-state and next-output logic for the job sequencer.
  always_comb begin
    state_d     = state_q;
    tap_rem_d   = tap_rem_q;
    oper_d      = oper_q;
    coef_d      = coef_q;
    clk_en_d    = 1'b0;
    clear_d     = 1'b0;
    rnd_d       = 1'b0;
    sat_d       = sat_q;
    tc_d        = tc_q;
    out_sel_d   = out_sel_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;

    if (seq_abort) begin
      state_d     = ST_IDLE;
      tap_rem_d   = TAP_ZERO;
      res_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            oper_d    = in_oper;
            coef_d    = in_coef;
            clk_en_d  = 1'b1;
            clear_d   = ~cfg_rnd;
            rnd_d     = cfg_rnd;
            sat_d     = cfg_sat;
            tc_d      = cfg_tc;
            out_sel_d = cfg_out_sel;
            tap_rem_d = cfg_taps;
            state_d   = (cfg_taps != TAP_ZERO) ? ST_RUN : ST_FLUSH;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (accept_s) begin
            oper_d    = in_oper;
            coef_d    = in_coef;
            clk_en_d  = 1'b1;
            tap_rem_d = tap_rem_q - TAP_ONE;
            state_d   = (tap_rem_q == TAP_ONE) ? ST_FLUSH : ST_RUN;
          end else begin
            state_d = ST_RUN;
          end
        end
        // The MAC performs its last update on this edge.
        ST_FLUSH: begin
          state_d = ST_CAPTURE;
        end
        ST_CAPTURE: begin
          res_data_d  = MAC_OUT;
          res_valid_d = 1'b1;
          state_d     = ST_RESULT;
        end
        ST_RESULT: begin
          if (res_ready) begin
            res_valid_d = 1'b0;
            state_d     = ST_IDLE;
          end else begin
            state_d = ST_RESULT;
          end
        end
        default: begin
          state_d     = ST_IDLE;
          tap_rem_d   = TAP_ZERO;
          res_valid_d = 1'b0;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; the MAC shares this reset net.
  always_ff @(posedge MAC_ACC_CLK or negedge acc_ff_rstn) begin
    if (!acc_ff_rstn) begin
      state_q     <= ST_IDLE;
      tap_rem_q   <= TAP_ZERO;
      oper_q      <= 4'h0;
      coef_q      <= 4'h0;
      clk_en_q    <= 1'b0;
      clear_q     <= 1'b0;
      rnd_q       <= 1'b0;
      sat_q       <= 1'b0;
      tc_q        <= 1'b0;
      out_sel_q   <= 6'd0;
      res_valid_q <= 1'b0;
      res_data_q  <= 4'h0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tap_rem_q   <= tap_rem_d;
      oper_q      <= oper_d;
      coef_q      <= coef_d;
      clk_en_q    <= clk_en_d;
      clear_q     <= clear_d;
      rnd_q       <= rnd_d;
      sat_q       <= sat_d;
      tc_q        <= tc_d;
      out_sel_q   <= out_sel_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready           = in_ready_s;
  assign MAC_OPER_DATA      = oper_q;
  assign MAC_COEF_DATA      = coef_q;
  assign EFPGA_MATHB_CLK_EN = clk_en_q;
  assign MAC_ACC_CLEAR      = clear_q;
  assign MAC_ACC_RND        = rnd_q;
  assign MAC_ACC_SAT        = sat_q;
  assign MAC_TC             = tc_q;
  assign MAC_OUT_SEL        = out_sel_q;
  assign res_valid          = res_valid_q;
  assign res_data           = res_data_q;
  assign busy               = busy_q;

endmodule
